// File: rtl/fast_window_if.sv
// Pixel-in / window-out handshake bundle for the FAST window sequencer.
// master = pixel source + corner scorer side, slave = controller.
interface fast_window_if #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  modport master (
    output pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_col, out_row
  );

  modport slave (
    input  pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_col, out_row
  );
endinterface

// File: rtl/fast_window_ctrl.sv
// Sequences the FAST 7-tap pixel window: loads the shift register, tracks the centre
// position and flags only in-row windows. Optional FAST_WIN_STATS_EN adds o_stall_cnt.
module fast_window_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DEPTH  = 7,
  parameter int CENTER = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_sr_load,
  output logic [7:0]  o_sr_data,
`ifdef FAST_WIN_STATS_EN
  output logic [31:0] o_stall_cnt,
`endif
  fast_window_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_out_valid;
  logic [CW-1:0] r_out_col;
  logic [RW-1:0] r_out_row;

  logic w_pix_ready;
  logic w_acc;
  logic w_last;

  assign w_pix_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
  assign w_acc       = bus.pix_valid && w_pix_ready;
  assign w_last      = (r_col == COL_MAX) && (r_row == ROW_MAX);

  assign bus.pix_ready = w_pix_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_col   = r_out_col;
  assign bus.out_row   = r_out_row;
  assign o_sr_load     = w_acc;
  assign o_sr_data     = bus.pix_data;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_done  = (r_state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= RUN;
          r_col   <= '0;
          r_row   <= '0;
        end
        RUN:   if (w_acc && w_last) r_state <= DRAIN;
        DRAIN: if (!r_out_valid || bus.out_ready) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_acc) begin
        if (r_col == COL_MAX) begin
          r_col <= '0;
          r_row <= (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      // A window whose oldest tap precedes column 0 would mix two rows; suppress it.
      if (w_acc) begin
        r_out_valid <= (r_col >= COL_MIN);
        if (r_col >= COL_MIN) begin
          r_out_col <= r_col - CW'(CENTER);
          r_out_row <= r_row;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef FAST_WIN_STATS_EN
  logic [31:0] r_stall_cnt;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_stall_cnt <= '0;
    end else if (r_state == RUN && bus.pix_valid && !w_pix_ready && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
